// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake bundle between fetch, the fetch queue and decode.
//   in_valid/in_ready/pc_in/instr_in  : fetch -> queue push side
//   out_valid/out_ready/pc_out/instr_out : queue -> decode pop side
//   count : current occupancy of the queue
// master = fetch/decode side driving the queue, slave = the queue itself.
interface fetch_queue_if #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DEPTH       = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                   in_valid;
  logic                   in_ready;
  logic [ADDR_WIDTH-1:0]  pc_in;
  logic [INSTR_WIDTH-1:0] instr_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [ADDR_WIDTH-1:0]  pc_out;
  logic [INSTR_WIDTH-1:0] instr_out;
  logic [CW-1:0]          count;

  modport master (
    output in_valid, pc_in, instr_in, out_ready,
    input  in_ready, out_valid, pc_out, instr_out, count
  );

  modport slave (
    input  in_valid, pc_in, instr_in, out_ready,
    output in_ready, out_valid, pc_out, instr_out, count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry circular buffer of {pc, instr} pairs between fetch
// and decode, with valid/ready on both sides and a synchronous flush.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   flush : synchronous discard of all queued entries (redirect)
//   q     : fetch_queue_if.slave handshake bundle (push side, pop side, count)
// All outputs on q are decoded from registered state only.
module fetch_queue #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DEPTH       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  fetch_queue_if.slave  q
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic   w_in_ready;
  logic   w_out_valid;
  logic   w_push;
  logic   w_pop;
  entry_t w_head;

  // Handshake decode; a full queue refuses a push even when popping.
  assign w_in_ready  = (r_count != CW'(DEPTH));
  assign w_out_valid = (r_count != CW'(0));
  assign w_push      = q.in_valid & w_in_ready;
  assign w_pop       = w_out_valid & q.out_ready;
  assign w_head      = r_mem[r_rd_ptr];

  assign q.in_ready  = w_in_ready;
  assign q.out_valid = w_out_valid;
  assign q.pc_out    = w_out_valid ? w_head.pc : '0;
  assign q.instr_out = w_out_valid ? w_head.instr : '0;
  assign q.count     = r_count;

  // Pointer and occupancy state; reset beats flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Entry storage needs no reset; stale slots are masked by r_count.
  always_ff @(posedge clk) begin
    if (!rst && !flush && w_push) begin
      r_mem[r_wr_ptr] <= '{pc: q.pc_in, instr: q.instr_in};
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue (DEPTH=4).
module tb_fetch_queue;
  localparam int unsigned AW = 12;
  localparam int unsigned IW = 32;
  localparam int unsigned D  = 4;

  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   failures;

  fetch_queue_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(D)) bus ();

  fetch_queue #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .q     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs change and outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [AW-1:0] pc, input logic [IW-1:0] ins);
    bus.in_valid = v;
    bus.pc_in    = pc;
    bus.instr_in = ins;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    bus.out_ready = 1'b0;
    set_in(1'b0, '0, '0);

    // Reset for two cycles, then idle.
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_pc_out",    64'(bus.pc_out),    64'(0));
    chk("rst_instr_out", 64'(bus.instr_out), 64'(0));
    chk("rst_in_ready",  64'(bus.in_ready),  64'(1));
    chk("rst_count",     64'(bus.count),     64'(0));

    // Fill to full.
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, AW'(4 * i), IW'(32'hA0 + i));
      step();
      if (i == 0) begin
        chk("first_push_valid", 64'(bus.out_valid), 64'(1));
        chk("first_push_pc",    64'(bus.pc_out),    64'(0));
        chk("first_push_instr", 64'(bus.instr_out), 64'hA0);
      end
    end
    chk("full_count",    64'(bus.count),    64'(4));
    chk("full_in_ready", 64'(bus.in_ready), 64'(0));

    // Fifth push is refused.
    set_in(1'b1, AW'(12'h010), IW'(32'hA4));
    step();
    chk("overfill_count", 64'(bus.count), 64'(4));
    set_in(1'b0, '0, '0);

    // Drain in order.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_pc_%0d", i),    64'(bus.pc_out),    64'(4 * i));
      chk($sformatf("drain_instr_%0d", i), 64'(bus.instr_out), 64'(32'hA0 + i));
      step();
    end
    chk("drained_valid", 64'(bus.out_valid), 64'(0));
    chk("drained_pc",    64'(bus.pc_out),    64'(0));
    chk("drained_instr", 64'(bus.instr_out), 64'(0));
    chk("drained_count", 64'(bus.count),     64'(0));
    bus.out_ready = 1'b0;

    // Pop on an empty queue has no effect.
    bus.out_ready = 1'b1;
    step();
    chk("empty_pop_count", 64'(bus.count), 64'(0));
    bus.out_ready = 1'b0;

    // Seed one entry, then concurrent push/pop across the pointer wrap.
    set_in(1'b1, AW'(12'h100), IW'(32'hB000_0100));
    step();
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      set_in(1'b1, AW'(12'h100 + 4 * k), IW'(32'hB000_0100 + 4 * k));
      chk($sformatf("wrap_pc_%0d", k), 64'(bus.pc_out), 64'(12'h100 + 4 * (k - 1)));
      step();
      chk($sformatf("wrap_count_%0d", k), 64'(bus.count), 64'(1));
    end
    chk("wrap_tail_pc",    64'(bus.pc_out),    64'(12'h128));
    chk("wrap_tail_instr", 64'(bus.instr_out), 64'(32'hB000_0128));
    set_in(1'b0, '0, '0);
    step();
    chk("wrap_drain_count", 64'(bus.count), 64'(0));
    bus.out_ready = 1'b0;

    // Build count=3, then flush with a concurrent push.
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, AW'(12'h300 + 4 * i), IW'(32'hC0 + i));
      step();
    end
    chk("preflush_count", 64'(bus.count), 64'(3));
    flush = 1'b1;
    set_in(1'b1, AW'(12'h3F0), IW'(32'hCF));
    step();
    flush = 1'b0;
    chk("flush_count",    64'(bus.count),     64'(0));
    chk("flush_valid",    64'(bus.out_valid), 64'(0));
    chk("flush_in_ready", 64'(bus.in_ready),  64'(1));
    chk("flush_pc",       64'(bus.pc_out),    64'(0));
    set_in(1'b1, AW'(12'h200), IW'(32'hD0));
    step();
    set_in(1'b0, '0, '0);
    chk("postflush_valid", 64'(bus.out_valid), 64'(1));
    chk("postflush_pc",    64'(bus.pc_out),    64'(12'h200));
    chk("postflush_instr", 64'(bus.instr_out), 64'hD0);
    chk("postflush_count", 64'(bus.count),     64'(1));

    // Reset mid-stream with push and pop both active.
    set_in(1'b1, AW'(12'h204), IW'(32'hD1));
    step();
    chk("premid_count", 64'(bus.count), 64'(2));
    rst = 1'b1;
    bus.out_ready = 1'b1;
    set_in(1'b1, AW'(12'h208), IW'(32'hD2));
    step();
    rst = 1'b0;
    bus.out_ready = 1'b0;
    set_in(1'b0, '0, '0);
    chk("midrst_count", 64'(bus.count),     64'(0));
    chk("midrst_valid", 64'(bus.out_valid), 64'(0));
    chk("midrst_pc",    64'(bus.pc_out),    64'(0));
    chk("midrst_instr", 64'(bus.instr_out), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised fetch queue between instruction fetch and decode, replacing the single-entry fetch pipeline register. It buffers up to DEPTH {pc, instr} pairs in a circular buffer with valid/ready handshakes on both sides, so fetch can run ahead while decode stalls. A synchronous flush discards all queued entries on a redirect (branch mispredict, exception).

## Interface
- ADDR_WIDTH, 12, PC width in bits
- INSTR_WIDTH, 32, instruction width in bits
- DEPTH, 4, number of entries; power of two, ≥ 2
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  synchronous discard of all entries
- in_valid  input  1  fetch presents a valid {pc_in, instr_in}
- in_ready  output  1  queue can accept an entry this cycle
- pc_in  input  ADDR_WIDTH  PC of incoming instruction
- instr_in  input  INSTR_WIDTH  incoming instruction word
- out_valid  output  1  head entry is valid
- out_ready  input  1  decode consumes head entry this cycle
- pc_out  output  ADDR_WIDTH  PC of head entry
- instr_out  output  INSTR_WIDTH  instruction of head entry
- count  output  $clog2(DEPTH+1)  number of occupied entries

## Operation
- Storage: DEPTH-entry array of {pc, instr}; write pointer wr_ptr, read pointer rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH naturally; occupancy counter count.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). No bypass: a full queue does not accept a push even if a pop occurs in the same cycle.
- out_valid = (count != 0). pc_out/instr_out = entry at rd_ptr when count != 0, else all zeros.
- On push: array[wr_ptr] ← {pc_in, instr_in}; wr_ptr ← wr_ptr+1.
- On pop: rd_ptr ← rd_ptr+1.
- count update: push only +1; pop only −1; both or neither unchanged.
- Simultaneous push and pop with count 1 or more is legal; the head advances and the new entry lands at the tail.
- Flush: wr_ptr, rd_ptr, count ← 0 next edge. Any push or pop in the same cycle is ignored. Array contents need not be cleared.
- Priority: rst > flush > push/pop.
- Reset: wr_ptr=rd_ptr=count=0. After the reset edge: out_valid=0, pc_out=0, instr_out=0, in_ready=1, count=0. Reset mid-operation discards all entries exactly like flush.
- in_valid while in_ready=0 is not an error. The entry is not captured and fetch must hold it.
- out_ready while out_valid=0 has no effect.

## Timing
- in_ready, out_valid, pc_out, instr_out are combinational from registered state only (pointers, count, array). There is no combinational path from in_valid/out_ready to any output.
- Push-to-output latency 1 cycle: an entry pushed at edge N into an empty queue gives out_valid=1 with that entry on pc_out/instr_out after edge N.
- Pop takes effect at the edge; the next entry (or zeros if empty) appears after that edge.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Flush asserted during cycle N: after edge N, count=0, out_valid=0, in_ready=1. A push in cycle N+1 is accepted normally.

## Test plan
- Reset then idle: assert rst for 2 cycles -> out_valid=0, pc_out=0, instr_out=0, in_ready=1, count=0.
- Fill to full (DEPTH=4): push pc 0x000,0x004,0x008,0x00C with instr 0xA0..0xA3 and out_ready=0 -> count=4, in_ready=0. A 5th push (pc 0x010) is not captured and count stays 4.
- Drain in order: from the full state set out_ready=1, in_valid=0 -> pc_out sequence 0x000,0x004,0x008,0x00C over 4 cycles, then out_valid=0, outputs 0.
- Wrap-around with concurrent push and pop: hold in_valid=1 and out_ready=1 for 10 cycles with incrementing pc 0x100+4k -> count stays at its initial value (1). Output order matches input order across the pointer wrap.
- Flush with concurrent push: with count=3, assert flush and in_valid together -> next cycle count=0, out_valid=0. A push of pc 0x200 next cycle appears at pc_out one cycle later.
- Reset mid-stream: with count=2 assert rst together with push and pop -> count=0, out_valid=0, pc_out=0 after the edge.
